// File: rtl/param_shift_unit.sv
// ============================================================================
// Module   : param_shift_unit
// Purpose  : WIDTH-bit universal shift register, multi-step ops, start/busy/done
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_shift_unit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic             si,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             so,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] c_op_nop  = 3'b000;
   localparam logic [2:0] c_op_load = 3'b001;
   localparam logic [2:0] c_op_ror  = 3'b010;
   localparam logic [2:0] c_op_shl  = 3'b011;
   localparam logic [2:0] c_op_shr  = 3'b100;
   localparam logic [2:0] c_op_asr  = 3'b101;
   localparam logic [2:0] c_op_rol  = 3'b110;
   localparam logic [2:0] c_op_clr  = 3'b111;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [2:0]       r_op;
   logic [AMT_W-1:0] r_cnt;

   logic [2:0]       w_sel_op;
   logic [WIDTH-1:0] w_step_q;
   logic             w_step_so;

   // The first step happens on the accepting edge, before r_op is valid
   assign w_sel_op = (r_state == S_SHIFT) ? r_op : op;

   always_comb begin
      w_step_q  = q;
      w_step_so = so;
      case (w_sel_op)
         c_op_ror: begin
            w_step_q  = {q[0], q[WIDTH-1:1]};
            w_step_so = q[0];
         end
         c_op_shl: begin
            w_step_q  = {q[WIDTH-2:0], si};
            w_step_so = q[WIDTH-1];
         end
         c_op_shr: begin
            w_step_q  = {si, q[WIDTH-1:1]};
            w_step_so = q[0];
         end
         c_op_asr: begin
            w_step_q  = {q[WIDTH-1], q[WIDTH-1:1]};
            w_step_so = q[0];
         end
         c_op_rol: begin
            w_step_q  = {q[WIDTH-2:0], q[WIDTH-1]};
            w_step_so = q[WIDTH-1];
         end
         default: begin
            w_step_q  = q;
            w_step_so = so;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= c_op_nop;
         r_cnt   <= '0;
         q       <= '0;
         so      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     c_op_nop: done <= 1'b1;
                     c_op_load: begin
                        q    <= d;
                        done <= 1'b1;
                     end
                     c_op_clr: begin
                        q    <= '0;
                        done <= 1'b1;
                     end
                     default: begin
                        r_op <= op;
                        if (amt == '0) begin
                           done <= 1'b1;
                        end else begin
                           q  <= w_step_q;
                           so <= w_step_so;
                           // A single-step op completes without ever raising busy
                           if (amt == AMT_W'(1)) begin
                              done <= 1'b1;
                           end else begin
                              busy    <= 1'b1;
                              r_cnt   <= amt - AMT_W'(1);
                              r_state <= S_SHIFT;
                           end
                        end
                     end
                  endcase
               end
            end
            S_SHIFT: begin
               q  <= w_step_q;
               so <= w_step_so;
               if (r_cnt <= AMT_W'(1)) begin
                  r_cnt   <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - AMT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_param_shift_unit.sv
// ============================================================================
// Module   : tb_param_shift_unit
// Purpose  : Scoreboard testbench for param_shift_unit (WIDTH=8, AMT_W=4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_shift_unit;

   localparam int WIDTH = 8;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [2:0]       op;
   logic [AMT_W-1:0] amt;
   logic             si;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             so;
   logic             busy;
   logic             done;

   param_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .amt   (amt),
      .si    (si),
      .d     (d),
      .q     (q),
      .so    (so),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] q;
      logic       so;
      int         busyc;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] m_q;
   logic       m_so;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: applies a whole op to m_q/m_so
   function automatic void model(input logic [2:0] o, input int n, input logic [7:0] dd,
                                 input logic s);
      case (o)
         3'd0: ;
         3'd1: m_q = dd;
         3'd7: m_q = 8'h00;
         default: begin
            for (int i = 0; i < n; i++) begin
               case (o)
                  3'd2: begin m_so = m_q[0]; m_q = (m_q >> 1) | {m_q[0], 7'b0}; end
                  3'd3: begin m_so = m_q[7]; m_q = (m_q << 1) | {7'b0, s}; end
                  3'd4: begin m_so = m_q[0]; m_q = (m_q >> 1) | {s, 7'b0}; end
                  3'd5: begin m_so = m_q[0]; m_q = (m_q >> 1) | (m_q & 8'h80); end
                  default: begin m_so = m_q[7]; m_q = (m_q << 1) | {7'b0, m_q[7]}; end
               endcase
            end
         end
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where done is observed
   task automatic run_op(input logic [2:0] o, input logic [3:0] n, input logic [7:0] dd,
                         input logic s, input bit poke);
      exp_t e;
      int   bc;
      bit   got;
      model(o, int'(n), dd, s);
      e.q     = m_q;
      e.so    = m_so;
      e.busyc = (o inside {[3'd2:3'd6]} && n > 1) ? int'(n) - 1 : 0;
      sb.push_back(e);
      start = 1'b1; op = o; amt = n; d = dd; si = s;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); amt = 4'($urandom); d = 8'($urandom);
      bc  = 0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         if (c > 0) @(negedge clk);
         check("busy_done_excl", {31'b0, busy & done}, 32'd0);
         if (done) begin
            got = 1'b1;
            e   = sb.pop_front();
            check("q", {24'b0, q}, {24'b0, e.q});
            check("so", {31'b0, so}, {31'b0, e.so});
            check("busy_cycles", bc, e.busyc);
         end else begin
            if (busy) bc++;
            if (poke && c == 0) begin
               start = 1'b1; op = 3'b111; d = 8'h00;
            end else begin
               start = 1'b0;
            end
         end
      end
      if (!got) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; op = 3'd0; amt = '0; d = '0; si = 1'b0;
      m_q = 8'h00; m_so = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_q", {24'b0, q}, 32'h0);
      check("rst_busy_done", {30'b0, busy, done}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Put something in q/so, then reset between edges
      run_op(3'd1, 4'd0, 8'h3C, 1'b0, 1'b0);
      run_op(3'd3, 4'd3, 8'h00, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_q", {24'b0, q}, 32'h0);
      check("async_so_busy_done", {29'b0, so, busy, done}, 32'h0);
      m_q = 8'h00; m_so = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_op(3'd1, 4'd0, 8'hA5, 1'b0, 1'b0);
      check("load_a5", {24'b0, q}, 32'hA5);
      @(negedge clk);
      check("load_done_width", {31'b0, done}, 32'd0);

      run_op(3'd2, 4'd3, 8'h00, 1'b0, 1'b0);
      check("ror3_q", {24'b0, q}, 32'hB4);
      check("ror3_so", {31'b0, so}, 32'd1);

      run_op(3'd1, 4'd0, 8'h81, 1'b0, 1'b0);
      run_op(3'd3, 4'd4, 8'h00, 1'b1, 1'b1);
      check("shl4_q", {24'b0, q}, 32'h1F);
      @(negedge clk);
      check("ignored_start_q", {24'b0, q}, 32'h1F);

      run_op(3'd1, 4'd0, 8'h90, 1'b0, 1'b0);
      run_op(3'd5, 4'd2, 8'h00, 1'b0, 1'b0);
      check("asr2_q", {24'b0, q}, 32'hE4);
      run_op(3'd6, 4'd8, 8'h00, 1'b0, 1'b0);
      check("rol8_q", {24'b0, q}, 32'hE4);

      run_op(3'd4, 4'd0, 8'h00, 1'b1, 1'b0);
      check("amt0_q", {24'b0, q}, 32'hE4);

      // Abort a long op with reset after four steps
      start = 1'b1; op = 3'd3; amt = 4'd9; si = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy", {31'b0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_q", {24'b0, q}, 32'h0);
      check("abort_so_busy_done", {29'b0, so, busy, done}, 32'h0);
      m_q = 8'h00; m_so = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", {31'b0, done}, 32'd0);
      end

      for (int k = 0; k < 12; k++) begin
         run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 8'($urandom),
                1'($urandom), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
